buffer_write_arbiter: RTL and testbench

// Shares the single write port of the buffer memory (in_data / ready / full) between NUM_REQ producers.

---
 rtl/buffer_write_arbiter_if.sv | 35 +++
 rtl/buffer_write_arbiter.sv | 131 +++++++++++++
 tb/tb_buffer_write_arbiter.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/buffer_write_arbiter_if.sv
//==============================================================================
// Module      : buffer_write_arbiter_if
// Description : Producer/buffer-side bundle of the buffer write arbiter.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface buffer_write_arbiter_if #(
    parameter int NUM_REQ       = 4,
    parameter int PAYLOAD_WIDTH = 32,
    parameter int ID_WIDTH      = 2,
    parameter int DATA_WIDTH    = 40
) ();
    logic [NUM_REQ-1:0]               req;
    logic [NUM_REQ-1:0]               req_last;
    logic [NUM_REQ*PAYLOAD_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]               grant;
    logic                             buf_ready;
    logic                             buf_full;
    logic [DATA_WIDTH-1:0]            buf_data;
    logic [ID_WIDTH-1:0]              owner;
    logic                             busy;

    modport master (
        output req, req_last, req_data, buf_ready, buf_full,
        input  grant, buf_data, owner, busy
    );

    modport slave (
        input  req, req_last, req_data, buf_ready, buf_full,
        output grant, buf_data, owner, busy
    );
endinterface

`default_nettype wire

// File: rtl/buffer_write_arbiter.sv
//==============================================================================
// Module      : buffer_write_arbiter
// Description : Packet-granular round-robin sharing of the buffer write port.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module buffer_write_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int PAYLOAD_WIDTH = 32,
    parameter int ID_WIDTH      = 2,
    parameter int DATA_WIDTH    = 40,
    parameter int MAX_BURST     = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    buffer_write_arbiter_if.slave bus
);

    localparam int                  c_CNT_W     = $clog2(MAX_BURST + 1);
    localparam logic [c_CNT_W-1:0]  c_MAX_BURST = c_CNT_W'(MAX_BURST);
    localparam logic [c_CNT_W-1:0]  c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [ID_WIDTH-1:0] c_LAST_IDX  = ID_WIDTH'(NUM_REQ - 1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t                   r_state, w_state_nxt;
    logic [ID_WIDTH-1:0]      r_rr_ptr, w_rr_ptr_nxt;
    logic [ID_WIDTH-1:0]      r_owner, w_owner_nxt;
    logic [c_CNT_W-1:0]       r_burst_cnt, w_burst_cnt_nxt;
    logic [DATA_WIDTH-1:0]    r_buf_data, w_buf_data_nxt;
    logic [ID_WIDTH-1:0]      w_pick_hi, w_pick_any, w_pick, w_src;
    logic                     w_found_hi, w_accept_ok, w_take;
    logic                     w_src_req, w_src_last;
    logic [PAYLOAD_WIDTH-1:0] w_src_payload;
    logic [NUM_REQ-1:0]       w_grant;

    function automatic logic [ID_WIDTH-1:0] f_next_idx(input logic [ID_WIDTH-1:0] idx);
        return (idx == c_LAST_IDX) ? '0 : idx + 1'b1;
    endfunction

    // A word still on buf_data blocks the next one, giving the mandatory idle gap.
    assign w_accept_ok = reset & bus.buf_ready & ~bus.buf_full & (r_buf_data == '0);

    always_comb begin
        w_pick_hi  = '0;
        w_pick_any = '0;
        w_found_hi = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req[i]) begin
                w_pick_any = ID_WIDTH'(i);
                if (ID_WIDTH'(i) >= r_rr_ptr) begin
                    w_pick_hi  = ID_WIDTH'(i);
                    w_found_hi = 1'b1;
                end
            end
        end
    end

    assign w_pick = w_found_hi ? w_pick_hi : w_pick_any;
    assign w_src  = (r_state == ST_IDLE) ? w_pick : r_owner;

    always_comb begin
        w_src_req     = 1'b0;
        w_src_last    = 1'b0;
        w_src_payload = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_src == ID_WIDTH'(i)) begin
                w_src_req     = bus.req[i];
                w_src_last    = bus.req_last[i];
                w_src_payload = bus.req_data[i*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_rr_ptr_nxt    = r_rr_ptr;
        w_owner_nxt     = r_owner;
        w_burst_cnt_nxt = r_burst_cnt;
        w_grant         = '0;
        w_buf_data_nxt  = '0;
        w_take          = w_accept_ok & w_src_req;
        if (w_take) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_src == ID_WIDTH'(i)) begin
                    w_grant[i] = 1'b1;
                end
            end
            w_buf_data_nxt[DATA_WIDTH-1]                = 1'b1;
            w_buf_data_nxt[DATA_WIDTH-2 -: ID_WIDTH]    = w_src;
            w_buf_data_nxt[DATA_WIDTH-2-ID_WIDTH]       = w_src_last;
            w_buf_data_nxt[PAYLOAD_WIDTH-1:0]           = w_src_payload;
            w_owner_nxt     = w_src;
            w_burst_cnt_nxt = (r_state == ST_IDLE) ? c_CNT_ONE : r_burst_cnt + c_CNT_ONE;
            if (w_src_last || (w_burst_cnt_nxt == c_MAX_BURST)) begin
                w_rr_ptr_nxt = f_next_idx(w_src);
                w_state_nxt  = ST_IDLE;
            end else begin
                w_state_nxt  = ST_LOCKED;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= '0;
            r_owner     <= '0;
            r_burst_cnt <= '0;
            r_buf_data  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_owner     <= w_owner_nxt;
            r_burst_cnt <= w_burst_cnt_nxt;
            r_buf_data  <= w_buf_data_nxt;
        end
    end

    assign bus.grant    = w_grant;
    assign bus.buf_data = r_buf_data;
    assign bus.owner    = r_owner;
    assign bus.busy     = (r_state == ST_LOCKED);

endmodule

`default_nettype wire

// File: tb/tb_buffer_write_arbiter.sv
//==============================================================================
// Module      : tb_buffer_write_arbiter
// Description : Randomised and directed bench with a behavioural arbiter model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_buffer_write_arbiter;

    localparam int N  = 4;
    localparam int PW = 32;
    localparam int DW = 40;
    localparam int MB = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    buffer_write_arbiter_if bus ();

    buffer_write_arbiter dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus.slave)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // producer state: total words still to send, packet length (0 = never last), position
    int          words_left [N];
    int          plen       [N];
    int          pos        [N];
    bit          wd         [N];
    logic [PW-1:0] pdata    [N];
    bit          t_rst, t_ready, t_full;

    // reference model of the arbiter
    int          m_rr     = 0;
    int          m_owner  = 0;
    int          m_cnt    = 0;
    bit          m_locked = 1'b0;
    logic [DW-1:0] m_buf  = '0;

    int            glog [$];
    int            blog [$];
    logic [DW-1:0] dlog [$];

    int exp2  [9] = '{0, -1, 1, -1, 2, -1, 3, -1, 0};
    int exp3g [7] = '{0, -1, 0, -1, 0, -1, 2};
    int exp3b [7] = '{0, 1, 1, 1, 1, 0, 0};
    int exp6  [4] = '{1, 2, 2, 0};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk_word(input int id, input bit last, input logic [PW-1:0] p);
        logic [1:0] id2;
        id2 = 2'(id);
        return {1'b1, id2, last, 4'b0000, p};
    endfunction

    task automatic step();
        logic [N-1:0]    r, l, eg;
        logic [N*PW-1:0] d;
        logic [DW-1:0]   nb;
        int              win, c, gi;
        bit              ok;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            r[i] = (words_left[i] > 0) && !wd[i];
            l[i] = (plen[i] != 0) && (pos[i] == plen[i] - 1);
            d[i*PW +: PW] = pdata[i];
        end
        rst_n         = t_rst;
        bus.req       = r;
        bus.req_last  = l;
        bus.req_data  = d;
        bus.buf_ready = t_ready;
        bus.buf_full  = t_full;
        #1;
        win = -1;
        ok  = t_rst && t_ready && !t_full && (m_buf == '0);
        if (ok) begin
            if (!m_locked) begin
                for (int k = 0; k < N; k++) begin
                    c = (m_rr + k) % N;
                    if (win < 0 && r[c]) win = c;
                end
            end else if (r[m_owner]) begin
                win = m_owner;
            end
        end
        eg = (win >= 0) ? (N'(1) << win) : '0;
        chk("grant",    bus.grant,    eg);
        chk("buf_data", bus.buf_data, m_buf);
        chk("owner",    bus.owner,    m_owner);
        chk("busy",     bus.busy,     m_locked);
        gi = -1;
        if ($countones(bus.grant) > 1) gi = -2;
        else for (int i = 0; i < N; i++) if (bus.grant[i]) gi = i;
        glog.push_back(gi);
        blog.push_back(int'(bus.busy));
        dlog.push_back(bus.buf_data);
        if (!t_rst) begin
            m_rr = 0; m_owner = 0; m_cnt = 0; m_locked = 1'b0; m_buf = '0;
        end else begin
            nb = '0;
            if (win >= 0) begin
                nb = mk_word(win, l[win], pdata[win]);
                if (!m_locked) begin
                    m_owner = win;
                    m_cnt   = 1;
                end else begin
                    m_cnt++;
                end
                if (l[win] || m_cnt == MB) begin
                    m_rr     = (win + 1) % N;
                    m_locked = 1'b0;
                end else begin
                    m_locked = 1'b1;
                end
                words_left[win]--;
                pos[win]   = (plen[win] != 0 && pos[win] + 1 == plen[win]) ? 0 : pos[win] + 1;
                pdata[win] = $urandom;
            end
            m_buf = nb;
        end
    endtask

    task automatic clear_prod();
        for (int i = 0; i < N; i++) begin
            words_left[i] = 0; plen[i] = 0; pos[i] = 0; wd[i] = 1'b0;
        end
    endtask

    task automatic set_prod(input int i, input int words, input int pl);
        words_left[i] = words; plen[i] = pl; pos[i] = 0;
    endtask

    task automatic do_reset(input int n);
        t_rst = 1'b0; t_ready = 1'b1; t_full = 1'b0;
        clear_prod();
        repeat (n) step();
        t_rst = 1'b1;
        glog.delete(); blog.delete(); dlog.delete();
    endtask

    initial begin
        int            f [$];
        logic [DW-1:0] w;
        int            pl;

        for (int i = 0; i < N; i++) pdata[i] = $urandom;
        clear_prod();
        t_rst = 1'b0; t_ready = 1'b1; t_full = 1'b0;
        rst_n = 1'b0;
        bus.req = '0; bus.req_last = '0; bus.req_data = '0;
        bus.buf_ready = 1'b1; bus.buf_full = 1'b0;
        @(posedge clk);

        // reset held with every producer requesting
        set_prod(0, 2, 1); set_prod(1, 1, 1); set_prod(2, 1, 1); set_prod(3, 1, 1);
        repeat (3) begin
            step();
            chk("rst_grant", bus.grant, 0);
            chk("rst_buf",   bus.buf_data, 0);
            chk("rst_owner", bus.owner, 0);
            chk("rst_busy",  bus.busy, 0);
        end

        // round robin over single-word packets
        t_rst = 1'b1;
        glog.delete(); blog.delete(); dlog.delete();
        repeat (9) step();
        for (int k = 0; k < 9; k++) begin
            chk("rr_seq", glog[k], exp2[k]);
            if (k % 2 == 1) begin
                w = dlog[k];
                chk("rr_msb", w[DW-1], 1);
                chk("rr_id",  w[DW-2 -: 2], glog[k-1]);
            end
        end

        // packet lock
        do_reset(2);
        set_prod(0, 3, 3); set_prod(2, 1, 1);
        repeat (7) step();
        for (int k = 0; k < 7; k++) begin
            chk("lock_grant", glog[k], exp3g[k]);
            chk("lock_busy",  blog[k], exp3b[k]);
        end

        // burst cap
        do_reset(2);
        set_prod(1, 20, 0); set_prod(3, 1, 1);
        repeat (50) step();
        f.delete();
        foreach (glog[k]) if (glog[k] != -1) f.push_back(glog[k]);
        chk("cap_count", f.size(), 21);
        for (int k = 0; k < 21 && k < f.size(); k++)
            chk("cap_seq", f[k], (k == 16) ? 3 : 1);

        // backpressure mid-packet
        do_reset(2);
        set_prod(0, 4, 4);
        step();
        t_full = 1'b1;
        repeat (10) step();
        t_full = 1'b0;
        repeat (10) step();
        chk("bp_first", glog[0], 0);
        for (int k = 1; k <= 10; k++) chk("bp_nogrant", glog[k], -1);
        for (int k = 2; k <= 10; k++) chk("bp_bufzero", dlog[k], 0);
        chk("bp_resume", glog[11], 0);
        f.delete();
        foreach (glog[k]) if (glog[k] != -1) f.push_back(glog[k]);
        chk("bp_words", f.size(), 4);

        // reset in the middle of a packet
        do_reset(2);
        set_prod(1, 1, 1);
        repeat (2) step();
        set_prod(2, 4, 4);
        repeat (4) step();
        t_rst = 1'b0;
        clear_prod();
        set_prod(0, 1, 1); set_prod(3, 1, 1);
        repeat (2) step();
        t_rst = 1'b1;
        step();
        chk("mrst_buf",   dlog[8], 0);
        chk("mrst_grant", glog[8], 0);
        f.delete();
        foreach (glog[k]) if (glog[k] >= 0) f.push_back(glog[k]);
        for (int k = 0; k < 4 && k < f.size(); k++) chk("mrst_seq", f[k], exp6[k]);

        // randomised traffic
        do_reset(2);
        repeat (4000) begin
            for (int i = 0; i < N; i++) begin
                wd[i] = 1'b0;
                if (words_left[i] == 0 && $urandom_range(3) == 0) begin
                    pl = $urandom_range(6);
                    if (pl == 0) set_prod(i, 1 + $urandom_range(23), 0);
                    else         set_prod(i, pl * (1 + $urandom_range(2)), pl);
                end else if (words_left[i] > 0 && $urandom_range(31) == 0) begin
                    wd[i] = 1'b1;
                end
            end
            t_ready = ($urandom_range(7) != 0);
            t_full  = ($urandom_range(7) == 0);
            t_rst   = ($urandom_range(699) != 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
